// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache port arbiter.
package cache_arb_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   // Width of a requester port index.
   // This is never less than one bit, so an index register always exists.
   function automatic int port_idx_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_picker.sv
// Combinational round-robin select.
// The search starts at ptr and wraps through the ports, so the first
// requesting port at or after ptr wins.
module rr_picker
   import cache_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IW      = port_idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IW-1:0]      idx
);

   logic [IW:0]   cand_sum;
   logic [IW-1:0] cand;

   // Scan from the farthest candidate back to ptr.
   // The last hit written is the closest requester, which is the winner.
   always_comb begin
      any      = 1'b0;
      onehot   = '0;
      idx      = '0;
      cand_sum = '0;
      cand     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_sum = {1'b0, ptr} + (IW+1)'(k);
         if (cand_sum >= (IW+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (IW+1)'(NUM_REQ);
         end
         cand = cand_sum[IW-1:0];
         if (req[cand]) begin
            any          = 1'b1;
            idx          = cand;
            onehot       = '0;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one direct-mapped cache between NUM_REQ ports.
// Only one transaction is ever in flight at a time.
// Flushes are sequenced between transactions.
// The arbiter drives the shared data bus only during the issue cycle of a write.
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_is_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rsp_vld,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_hit,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic [ADDR_WIDTH-1:0]         cache_addr,
   output logic                          cache_addr_en,
   output logic                          cache_is_rd,
   output logic                          cache_flush,
   inout  logic [DATA_WIDTH-1:0]         cache_data,
   inout  logic                          cache_data_vld,
   input  logic                          cache_is_hit,
   input  logic                          cache_busy
);

   localparam int IW = port_idx_width(NUM_REQ);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t                state_reg;
   logic [IW-1:0]         ptr_reg;
   logic [IW-1:0]         winner_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  drive_reg;
   logic [CW-1:0]         flush_cnt_reg;

   logic                  pick_any;
   logic [NUM_REQ-1:0]    pick_onehot;
   logic [IW-1:0]         pick_idx;

   logic [ADDR_WIDTH-1:0] port_addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] port_wdata [NUM_REQ];

   // Split the flat per-port buses into indexable arrays.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign port_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign port_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_reg),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // The shared bus is driven only while a write is being issued.
   // At all other times it is released.
   assign cache_data     = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
   assign cache_data_vld = drive_reg ? 1'b1 : 1'bz;

   // Main sequencer: arbitration, issue, completion and flush sequencing.
   // All outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         winner_reg    <= '0;
         wdata_reg     <= '0;
         drive_reg     <= 1'b0;
         flush_cnt_reg <= '0;
         gnt           <= '0;
         rsp_vld       <= '0;
         flush_done    <= 1'b0;
         cache_addr_en <= 1'b0;
         cache_flush   <= 1'b0;
         cache_addr    <= '0;
         cache_is_rd   <= 1'b1;
         rsp_rdata     <= '0;
         rsp_hit       <= 1'b0;
      end else begin
         gnt        <= '0;
         rsp_vld    <= '0;
         flush_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (flush_req && !cache_busy) begin
                  cache_flush   <= 1'b1;
                  flush_cnt_reg <= '0;
                  state_reg     <= FLUSH;
               end else if (pick_any && !cache_busy) begin
                  gnt           <= pick_onehot;
                  winner_reg    <= pick_idx;
                  cache_addr    <= port_addr[pick_idx];
                  cache_is_rd   <= req_is_rd[pick_idx];
                  wdata_reg     <= port_wdata[pick_idx];
                  drive_reg     <= !req_is_rd[pick_idx];
                  cache_addr_en <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               cache_addr_en <= 1'b0;
               drive_reg     <= 1'b0;
               state_reg     <= WAIT;
            end
            WAIT: begin
               // Reads finish on returned data; writes finish when the cache is no longer busy.
               if (cache_is_rd ? cache_data_vld : !cache_busy) begin
                  rsp_vld <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_reg;
                  rsp_hit <= cache_is_hit;
                  if (cache_is_rd) begin
                     rsp_rdata <= cache_data;
                  end
                  ptr_reg   <= (winner_reg == IW'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
                  state_reg <= IDLE;
               end
            end
            FLUSH: begin
               if (flush_cnt_reg == CW'(FLUSH_CYCLES - 1)) begin
                  cache_flush <= 1'b0;
                  flush_done  <= 1'b1;
                  state_reg   <= IDLE;
               end else begin
                  flush_cnt_reg <= flush_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter with three requester ports and a behavioural cache stub.
// A stimulus process predicts each transaction's outcome from the arbitration and memory rules.
// A monitor process checks what the DUT presents.
module tb_cache_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int F  = 2;

   typedef struct {
      int          port;
      logic [DW-1:0] rdata;
      bit          hit;
   } rsp_t;

   typedef struct {
      logic [AW-1:0] addr;
      bit            rd;
      logic [DW-1:0] wd;
   } iss_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_is_rd;
   logic [N*DW-1:0] req_wdata;
   logic            flush_req;
   logic            cache_is_hit;
   logic            cache_busy;
   wire  [N-1:0]    gnt;
   wire  [N-1:0]    rsp_vld;
   wire  [DW-1:0]   rsp_rdata;
   wire             rsp_hit;
   wire             flush_done;
   wire  [AW-1:0]   cache_addr;
   wire             cache_addr_en;
   wire             cache_is_rd;
   wire             cache_flush;
   tri   [DW-1:0]   cache_data;
   tri              cache_data_vld;

   logic            stub_drv;
   logic [DW-1:0]   stub_data;

   assign cache_data     = stub_drv ? stub_data : {DW{1'bz}};
   assign cache_data_vld = stub_drv ? 1'b1 : 1'bz;

   cache_port_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .NUM_REQ      (N),
      .FLUSH_CYCLES (F)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_addr       (req_addr),
      .req_is_rd      (req_is_rd),
      .req_wdata      (req_wdata),
      .gnt            (gnt),
      .rsp_vld        (rsp_vld),
      .rsp_rdata      (rsp_rdata),
      .rsp_hit        (rsp_hit),
      .flush_req      (flush_req),
      .flush_done     (flush_done),
      .cache_addr     (cache_addr),
      .cache_addr_en  (cache_addr_en),
      .cache_is_rd    (cache_is_rd),
      .cache_flush    (cache_flush),
      .cache_data     (cache_data),
      .cache_data_vld (cache_data_vld),
      .cache_is_hit   (cache_is_hit),
      .cache_busy     (cache_busy)
   );

   initial forever #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [N-1:0]  gntq[$];
   rsp_t          rspq[$];
   iss_t          issq[$];
   int            ref_ptr = 0;
   logic [DW-1:0] ref_mem[logic [AW-1:0]];
   bit            ref_valid[logic [AW-1:0]];
   logic [DW-1:0] last_rdata = '0;
   logic [DW-1:0] s_mem[logic [AW-1:0]];
   bit            s_valid[logic [AW-1:0]];
   bit            rand_en = 0;
   bit            mon_en = 0;
   bit            outstanding = 0;
   bit            flush_seen = 0;
   int            force_lat = -1;
   int            stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event missing or unexpected (got none/extra, expected exactly one)", name);
   endtask

   // Value returned by the backing store for a never-written address.
   function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   task automatic post(input int p, input logic [AW-1:0] a, input bit rd, input logic [DW-1:0] d);
      req_addr[p*AW +: AW]  = a;
      req_is_rd[p]          = rd;
      req_wdata[p*DW +: DW] = d;
      req[p]                = 1'b1;
   endtask

   // One clock of stimulus.
   // On a grant, predict the winner and the transaction result.
   task automatic step();
      int            w;
      int            p;
      logic [N-1:0]  eg;
      logic [AW-1:0] a;
      rsp_t          r;
      iss_t          it;
      @(posedge clk);
      #1;
      if (cache_flush && !flush_seen) ref_valid.delete();
      flush_seen = cache_flush;
      if (gnt != '0) begin
         w  = -1;
         eg = '0;
         if (!flush_req) begin
            for (int k = 0; k < N; k++) begin
               p = (ref_ptr + k) % N;
               if (w < 0 && req[p]) w = p;
            end
         end
         if (w >= 0) eg[w] = 1'b1;
         gntq.push_back(eg);
         if (w >= 0) begin
            a       = req_addr[w*AW +: AW];
            it.addr = a;
            it.rd   = req_is_rd[w];
            it.wd   = req_wdata[w*DW +: DW];
            r.port  = w;
            r.hit   = ref_valid.exists(a);
            ref_valid[a] = 1'b1;
            if (it.rd) last_rdata = ref_mem.exists(a) ? ref_mem[a] : fill(a);
            else       ref_mem[a] = it.wd;
            r.rdata = last_rdata;
            rspq.push_back(r);
            issq.push_back(it);
            ref_ptr = (w + 1) % N;
            req[w]  = 1'b0;
         end
         stall = 0;
      end else if (req != '0) begin
         stall++;
         if (stall > 100) begin
            fail("gnt_timeout");
            req   = '0;
            stall = 0;
         end
      end
      if (flush_done) flush_req = 1'b0;
      if (rand_en) begin
         for (int q = 0; q < N; q++) begin
            if (!req[q] && $urandom_range(0, 2) == 0) begin
               post(q, AW'(16'h1000 + $urandom_range(0, 7)), bit'($urandom_range(0, 1)), DW'($urandom));
            end
         end
         if (!flush_req && $urandom_range(0, 29) == 0) flush_req = 1'b1;
      end
   endtask

   task automatic step_until_gnt(input string name);
      for (int i = 0; i < 50; i++) begin
         step();
         if (gnt != '0) return;
      end
      fail(name);
   endtask

   task automatic run_until_idle(input string name, input int max);
      for (int i = 0; i < max; i++) begin
         step();
         if (req == '0 && !flush_req && rspq.size() == 0) begin
            step();
            step();
            return;
         end
      end
      fail(name);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_gnt"},        32'(gnt), 0);
      chk({tag, "_rsp_vld"},    32'(rsp_vld), 0);
      chk({tag, "_flush_done"}, 32'(flush_done), 0);
      chk({tag, "_addr_en"},    32'(cache_addr_en), 0);
      chk({tag, "_cflush"},     32'(cache_flush), 0);
      chk({tag, "_caddr"},      32'(cache_addr), 0);
      chk({tag, "_is_rd"},      32'(cache_is_rd), 1);
      chk({tag, "_rdata"},      32'(rsp_rdata), 0);
      chk({tag, "_hit"},        32'(rsp_hit), 0);
      chk({tag, "_bus_rel"},    32'(cache_data_vld === 1'b1), 0);
   endtask

   // Cache stub: latches the issued operation and returns data or finishes a write after a random latency.
   initial begin
      int            lat_cnt;
      int            lat;
      bit            pend_rd;
      bit            pend_wr;
      logic [AW-1:0] a;
      stub_drv     = 1'b0;
      stub_data    = '0;
      cache_busy   = 1'b0;
      cache_is_hit = 1'b0;
      pend_rd      = 0;
      pend_wr      = 0;
      lat_cnt      = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            stub_drv   = 1'b0;
            cache_busy = 1'b0;
            pend_rd    = 0;
            pend_wr    = 0;
            continue;
         end
         if (cache_flush) s_valid.delete();
         stub_drv = 1'b0;
         if (pend_rd) begin
            if (lat_cnt == 0) begin
               stub_drv = 1'b1;
               pend_rd  = 0;
            end else lat_cnt--;
         end
         if (pend_wr) begin
            if (lat_cnt == 0) begin
               cache_busy = 1'b0;
               pend_wr    = 0;
            end else lat_cnt--;
         end
         if (cache_addr_en) begin
            a            = cache_addr;
            lat          = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            cache_is_hit = s_valid.exists(a);
            s_valid[a]   = 1'b1;
            if (cache_is_rd) begin
               stub_data = s_mem.exists(a) ? s_mem[a] : fill(a);
               pend_rd   = 1;
               lat_cnt   = lat;
            end else begin
               s_mem[a] = cache_data;
               if (lat > 0) begin
                  cache_busy = 1'b1;
                  pend_wr    = 1;
                  lat_cnt    = lat - 1;
               end
            end
         end
      end
   end

   // Monitor: compare everything the DUT presents against the predicted queues.
   initial begin
      bit   fl_prev;
      int   fl_cnt;
      iss_t it;
      rsp_t r;
      fl_prev = 0;
      fl_cnt  = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            fl_prev     = 0;
            fl_cnt      = 0;
            outstanding = 0;
            continue;
         end
         if (gnt != '0) begin
            chk("gnt_overlap", 32'(outstanding), 0);
            if (gntq.size() == 0) fail("gnt_unexpected");
            else                  chk("gnt", 32'(gnt), 32'(gntq.pop_front()));
            outstanding = 1;
         end
         if (cache_addr_en) begin
            if (issq.size() == 0) fail("issue_unexpected");
            else begin
               it = issq.pop_front();
               chk("issue_addr", 32'(cache_addr), 32'(it.addr));
               chk("issue_is_rd", 32'(cache_is_rd), 32'(it.rd));
               if (!it.rd) begin
                  chk("issue_wvld", 32'(cache_data_vld === 1'b1), 1);
                  chk("issue_wdata", 32'(cache_data), 32'(it.wd));
               end else begin
                  chk("issue_rd_bus_rel", 32'(cache_data_vld === 1'b1), 0);
               end
            end
         end else if (!stub_drv) begin
            chk("bus_released", 32'(cache_data_vld === 1'b1), 0);
         end
         if (rsp_vld != '0) begin
            if (rspq.size() == 0) fail("rsp_unexpected");
            else begin
               r = rspq.pop_front();
               $display("rsp port %0d rdata %02h hit %0d", r.port, rsp_rdata, rsp_hit);
               chk("rsp_vld", 32'(rsp_vld), 32'(1) << r.port);
               chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
               chk("rsp_hit", 32'(rsp_hit), 32'(r.hit));
            end
            outstanding = 0;
         end
         if (cache_flush) begin
            if (!fl_prev) chk("flush_overlap", 32'(outstanding), 0);
            fl_cnt++;
            chk("gnt_in_flush", 32'(gnt), 0);
         end else if (fl_prev) begin
            $display("flush held %0d cycles", fl_cnt);
            chk("flush_len", 32'(fl_cnt), F);
            chk("flush_done", 32'(flush_done), 1);
            fl_cnt = 0;
         end else if (flush_done) begin
            fail("flush_done_spurious");
         end
         fl_prev = cache_flush;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_addr  = '0;
      req_is_rd = '0;
      req_wdata = '0;
      flush_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst    = 1'b0;
      mon_en = 1;

      // Write then read the same address on port 0.
      post(0, 16'habcd, 0, 8'haa);
      run_until_idle("drain_wr", 50);
      post(0, 16'habcd, 1, 8'h00);
      run_until_idle("drain_rd", 50);

      // Ports 0 and 1 keep requesting reads, so the grants should alternate.
      for (int i = 0; i < 4; i++) begin
         if (!req[0]) post(0, 16'h1001, 1, 8'h00);
         if (!req[1]) post(1, 16'h1002, 1, 8'h00);
         step_until_gnt("alt_gnt");
      end
      run_until_idle("drain_alt", 80);

      // All three ports request together, so the pointer has to wrap.
      for (int i = 0; i < 4; i++) begin
         for (int q = 0; q < N; q++) if (!req[q]) post(q, AW'(16'h1004 + q), 1, 8'h00);
         step_until_gnt("wrap_gnt");
      end
      run_until_idle("drain_wrap", 80);

      // Raise a flush while a port 1 read is waiting.
      post(1, 16'h1003, 1, 8'h00);
      step_until_gnt("flush_rd_gnt");
      step();
      flush_req = 1'b1;
      run_until_idle("drain_flush_wait", 60);

      // Flush and a request arrive in the same idle cycle.
      post(0, 16'h1003, 1, 8'h00);
      flush_req = 1'b1;
      run_until_idle("drain_flush_req", 60);

      // Randomised traffic with occasional flushes.
      rand_en = 1;
      repeat (800) step();
      rand_en = 0;
      run_until_idle("drain_rand", 400);

      // Reset while a write is waiting on a busy cache.
      force_lat = 6;
      post(0, 16'h2222, 0, 8'h5c);
      step_until_gnt("rst_wr_gnt");
      step();
      rst    = 1'b1;
      mon_en = 0;
      @(posedge clk);
      #1;
      rspq.delete();
      issq.delete();
      gntq.delete();
      ref_ptr    = 0;
      last_rdata = '0;
      check_reset_vals("midrst");
      rst       = 1'b0;
      force_lat = -1;
      @(posedge clk);
      #1;
      chk("midrst_no_rsp", 32'(rsp_vld), 0);
      mon_en = 1;

      // After reset, port 0 must be the highest priority again.
      post(1, 16'h2222, 1, 8'h00);
      post(0, 16'h2222, 1, 8'h00);
      run_until_idle("drain_post_rst", 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Round-robin arbiter that shares one direct_cache between NUM_REQ requester ports, for example the CPU instruction and data ports.
- Serialises read and write transactions onto the cache's single addr/addr_en/is_rd/data/data_vld interface and owns the tri-state drive of the shared cache data bus.
- Sequences cache flush requests so a flush never overlaps a transaction in flight.
- Returns read data and hit status to the granted requester.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 8, data width.
- NUM_REQ, 2, number of requester ports (2..8).
- FLUSH_CYCLES, 2, cycles the cache flush input is held high.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-port request, level, held until gnt.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_is_rd  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  per-port write data.
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_vld  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_vld.
- rsp_hit  out  1  cache is_hit captured at completion, valid with rsp_vld.
- flush_req  in  1  level, request cache flush.
- flush_done  out  1  one-cycle pulse when the flush sequence ends.
- cache_addr  out  ADDR_WIDTH  to direct_cache addr.
- cache_addr_en  out  1  to direct_cache addr_en.
- cache_is_rd  out  1  to direct_cache is_rd.
- cache_flush  out  1  to direct_cache flush.
- cache_data  inout  DATA_WIDTH  shared bus; driven only while cache_data_vld is driven high, else 'z.
- cache_data_vld  inout  1  driven 1 with write data during ISSUE of a write, else 'z; sampled as input otherwise.
- cache_is_hit  in  1  from direct_cache is_hit.
- cache_busy  in  1  from direct_cache cache_busy.

Behaviour:
- Reset, synchronous: state = IDLE, round-robin pointer = port 0 highest priority.
- Reset values of outputs:
  - gnt, rsp_vld, flush_done = 0.
  - cache_addr_en, cache_flush = 0.
  - cache_addr = 0, cache_is_rd = 1, rsp_rdata = 0, rsp_hit = 0.
  - cache_data and cache_data_vld released ('z).
- Reset mid-transaction aborts it. No rsp_vld is issued for the aborted request, and the bus is released in the same cycle.
- States: IDLE, ISSUE, WAIT, FLUSH.
- IDLE:
  - If flush_req = 1 and cache_busy = 0: go to FLUSH. Flush has priority over pending requests.
  - Else if any req and cache_busy = 0: pick the winner round-robin, starting from the port after the last winner.
  - On a pick: pulse gnt[w], register addr/is_rd/wdata and winner index, go to ISSUE.
- ISSUE, exactly one cycle:
  - cache_addr_en = 1, cache_addr and cache_is_rd = registered values.
  - For a write, also drive cache_data = wdata and cache_data_vld = 1.
  - Next state: WAIT.
- WAIT:
  - The bus is released (cache_data and cache_data_vld = 'z).
  - Read completes on the first cycle the sampled cache_data_vld = 1: capture cache_data into rsp_rdata.
  - Write completes on the first cycle cache_busy = 0.
  - On completion: pulse rsp_vld[winner], capture cache_is_hit into rsp_hit, update the pointer to winner+1 mod NUM_REQ, go to IDLE.
- FLUSH:
  - Hold cache_flush = 1 for FLUSH_CYCLES cycles using a counter.
  - Then pulse flush_done and go to IDLE.
  - gnt stays 0 throughout FLUSH.
- Throughput: at most one transaction outstanding. Minimum turnaround is gnt to rsp_vld = 2 cycles; the next gnt can come no earlier than the cycle after rsp_vld.
- Latency: gnt occurs in the cycle req is sampled in IDLE. A request deasserted before gnt is simply not served.
- Simultaneous flush_req and req in IDLE: flush wins. The requests are served after flush_done in round-robin order; the pointer is unchanged by a flush.
- Pointer wrap: after port NUM_REQ-1 wins, port 0 becomes highest priority.
- rsp_rdata and rsp_hit hold their last value between completions. rsp_rdata is unchanged on write completion.
- No bus contention: the arbiter drives cache_data only in ISSUE of a write.

Decomposition:
- Package cache_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, FLUSH}.
  - function for the width of a port index, $clog2(NUM_REQ).
- Sub-module rr_picker (NUM_REQ): combinational round-robin select from the req vector and the pointer; outputs one-hot plus index.
- The FSM, pointer and bus drivers stay in cache_port_arbiter.

Test Plan:
1. Port 0 write 16'habcd/8'haa, then port 0 read 16'habcd -> gnt[0] pulses twice; the read rsp_vld[0] has rsp_rdata = 8'haa and rsp_hit = 1.
2. Ports 0 and 1 hold req continuously, both reads -> grants alternate 0,1,0,1. Each rsp_vld precedes the next gnt, and the grants never overlap.
3. NUM_REQ = 3 with all three requesting -> grant order 0,1,2,0; the pointer wraps after port 2.
4. flush_req asserted while a port 1 read is in WAIT -> the read completes first. cache_flush is then high for exactly 2 cycles, followed by a flush_done pulse, and no gnt during FLUSH.
5. flush_req and req[0] in the same IDLE cycle -> FLUSH first, then gnt[0] after flush_done.
6. rst asserted during WAIT of a write -> the next cycle has all outputs at reset values, cache_data = 'z, and no rsp_vld.
